// File: rtl/timer_regressivo_bcd_pkg.sv
// rtl/timer_regressivo_bcd_pkg.sv - shared state encoding and digit constants for the BCD countdown timer
package timer_regressivo_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX         = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX    = 4'd5;
  localparam logic [3:0] ADD30_TENS      = 4'd3;
  localparam logic [3:0] QUICK_SECS_TENS = 4'd3;

endpackage

// File: rtl/timer_regressivo_bcd_digit_cell.sv
// rtl/timer_regressivo_bcd_digit_cell.sv - one BCD digit with load, borrow-chained decrement and carry-chained increment
module bcd_digit_cell #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       load_en,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  input  logic       borrow_in,
  output logic       borrow_out,
  input  logic       inc_en,
  input  logic       carry_in,
  output logic       carry_out,
  output logic [3:0] digit_o,
  output logic       is_zero
);

  logic [3:0] digit_q, digit_d;

  assign digit_o    = digit_q;
  assign is_zero    = (digit_q == 4'd0);
  assign borrow_out = borrow_in && is_zero;
  assign carry_out  = carry_in && (digit_q == MAX);

  // Tens may hold 6..9 from the keypad; only the 0 case wraps to MAX.
  always_comb begin
    digit_d = digit_q;
    if (load_en) begin
      digit_d = load_val;
    end else if (dec_en && borrow_in) begin
      digit_d = is_zero ? MAX : digit_q - 4'd1;
    end else if (inc_en && carry_in) begin
      digit_d = (digit_q == MAX) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    digit_q <= digit_d;
  end

endmodule

// File: rtl/timer_regressivo_bcd.sv
// rtl/timer_regressivo_bcd.sv - BCD countdown timer: keypad shift-in, 1 Hz countdown, pause/resume, +30 s, quick start
module timer_regressivo_bcd
  import timer_regressivo_bcd_pkg::*;
#(
  parameter int MIN_DIGITS  = 1,
  parameter bit QUICK_START = 1'b1
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic [3:0]                  digit_in,
  input  logic                        digit_valid,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        cancel,
  input  logic                        tick,
  output logic [4*(MIN_DIGITS+2)-1:0] time_bcd,
  output logic                        running,
  output logic                        zero,
  output logic                        done
);

  localparam int ND = MIN_DIGITS + 2;

  state_e        state_q, state_d;
  logic          done_q, done_d;
  logic [3:0]    dig [ND];
  logic [ND-1:0] is_zero_v;
  logic [ND-1:0] load_en;
  logic [3:0]    load_val [ND];
  logic          dec_go, add_go;
  logic [4:0]    tens_sum;
  logic          add_carry;
  logic [3:0]    tens_new;
  logic          underflow, overflow, one_sec;

  assign tens_sum  = {1'b0, dig[1]} + {1'b0, ADD30_TENS};
  assign add_carry = (tens_sum >= 5'd6);
  assign tens_new  = add_carry ? 4'(tens_sum - 5'd6) : tens_sum[3:0];

  for (genvar i = 0; i < ND; i++) begin : g_dig
    logic b_in, b_out, c_in, c_out;
    if (i == 0) begin : g_lsd
      assign b_in = 1'b1;
      assign c_in = 1'b0;
    end else if (i == 2) begin : g_min0
      assign b_in = g_dig[i-1].b_out;
      assign c_in = g_dig[i-1].c_out | add_carry;
    end else begin : g_mid
      assign b_in = g_dig[i-1].b_out;
      assign c_in = g_dig[i-1].c_out;
    end

    bcd_digit_cell #(
      .MAX((i == 1) ? SEC_TENS_MAX : BCD_MAX)
    ) u_cell (
      .clk        (clk),
      .load_en    (load_en[i]),
      .load_val   (load_val[i]),
      .dec_en     (dec_go),
      .borrow_in  (b_in),
      .borrow_out (b_out),
      .inc_en     (add_go),
      .carry_in   (c_in),
      .carry_out  (c_out),
      .digit_o    (dig[i]),
      .is_zero    (is_zero_v[i])
    );

    assign time_bcd[4*i +: 4] = dig[i];
  end

  // Borrow out of the top digit means the time is already zero; carry out means +30 s overflows.
  assign underflow = g_dig[ND-1].b_out;
  assign overflow  = g_dig[ND-1].c_out;
  assign one_sec   = (dig[0] == 4'd1) && (&is_zero_v[ND-1:1]);
  assign zero      = &is_zero_v;
  assign running   = (state_q == RUN);
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    load_en = '0;
    for (int i = 0; i < ND; i++) load_val[i] = 4'd0;
    dec_go  = 1'b0;
    add_go  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      load_en = '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cancel) begin
            load_en = '1;
          end else if (start && !zero) begin
            state_d = RUN;
          end else if (start && QUICK_START) begin
            load_en     = '1;
            load_val[1] = QUICK_SECS_TENS;
            state_d     = RUN;
          end else if (digit_valid && (digit_in <= BCD_MAX)) begin
            load_en     = '1;
            load_val[0] = digit_in;
            for (int i = 1; i < ND; i++) load_val[i] = dig[i-1];
          end
        end
        RUN: begin
          if (cancel || pause) begin
            state_d = PAUSE;
          end else if (start) begin
            if (!overflow) begin
              add_go      = 1'b1;
              load_en[1]  = 1'b1;
              load_val[1] = tens_new;
            end
          end else if (tick && !underflow) begin
            dec_go = 1'b1;
            if (one_sec) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (cancel) begin
            load_en = '1;
            state_d = IDLE;
          end else if (start) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

endmodule
